mux2_rr_arbiter: RTL



---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/hold_counter.sv | 26 ++
 rtl/mux2_rr_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared encodings for the 2:1 mux round-robin arbiter: FSM states and mux select values.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/hold_counter.sv
// Saturating up-counter with synchronous clear; counts consecutive granted cycles.
module hold_counter #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 2:1 mux, with bounded hold
// time and a one-cycle grant-free turnaround between owners.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic             target_q, target_d;
  logic             last_q, last_d;
  logic             sel_d;
  logic             hold_clr, hold_inc;
  logic [CNT_W-1:0] hold_cnt;

  // Owner has used its share once the MAX_HOLD-th cycle is reached (or exceeded via saturation).
  logic hold_spent;
  assign hold_spent = (hold_cnt >= HOLD_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q == SEL_B)) state_d = GNT_A;
        else if (req_b)                           state_d = GNT_B;
      end
      GNT_A: begin
        if (req_b && (!req_a || hold_spent)) begin
          state_d  = TURN;
          target_d = SEL_B;
        end else if (!req_a) begin
          state_d = IDLE;
        end
      end
      GNT_B: begin
        if (req_a && (!req_b || hold_spent)) begin
          state_d  = TURN;
          target_d = SEL_A;
        end else if (!req_b) begin
          state_d = IDLE;
        end
      end
      TURN: begin
        // Target may have withdrawn during the turnaround; fall back to the other side directly.
        if (target_q == SEL_A) begin
          if (req_a)      state_d = GNT_A;
          else if (req_b) state_d = GNT_B;
          else            state_d = IDLE;
        end else begin
          if (req_b)      state_d = GNT_B;
          else if (req_a) state_d = GNT_A;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d  = sel;
    last_d = last_q;
    case (state_d)
      GNT_A: begin
        sel_d  = SEL_A;
        last_d = SEL_A;
      end
      GNT_B: begin
        sel_d  = SEL_B;
        last_d = SEL_B;
      end
      TURN:    sel_d = target_d;
      default: sel_d = sel;
    endcase
  end

  assign hold_clr = (state_d != state_q);
  assign hold_inc = (state_q == GNT_A || state_q == GNT_B) && !hold_clr;

  hold_counter #(
    .CNT_W (CNT_W),
    .LIMIT (MAX_HOLD)
  ) u_hold_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hold_clr),
    .inc   (hold_inc),
    .cnt   (hold_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= SEL_A;
      last_q     <= SEL_B;
      sel        <= SEL_A;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      busy       <= 1'b0;
      switch_cnt <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      last_q   <= last_d;
      sel      <= sel_d;
      gnt_a    <= (state_d == GNT_A);
      gnt_b    <= (state_d == GNT_B);
      busy     <= (state_d != IDLE);
      if (state_q == TURN) switch_cnt <= switch_cnt + CNT_W'(1);
    end
  end

endmodule
